// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial 4-digit packed-BCD adder/controller sharing one 1-digit BCD adder.
// Optional macro BCD_SUB_EN adds nine's-complement subtraction selected by sub.
module bcd_serial_add_ctrl (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        sub,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] sum,
   output logic        cout,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_idx;
   logic        r_carry;
   logic        r_inv;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_sum;
   logic        r_cout;
   logic        r_err;
   logic        r_busy;
   logic        r_done;

   logic        w_bad;
   logic        w_sub;
   logic [3:0]  w_a_dig;
   logic [3:0]  w_b_raw;
   logic [3:0]  w_b_dig;
   logic [4:0]  w_s;
   logic [3:0]  w_digit;
   logic        w_c;

   // True when any nibble of v is not a decimal digit
   function automatic logic has_bad_digit(input logic [15:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction

   assign w_bad = has_bad_digit(A) | has_bad_digit(B);

`ifdef BCD_SUB_EN
   logic r_sub;
   assign w_sub   = sub;
   assign w_b_dig = r_sub ? (4'd9 - w_b_raw) : w_b_raw;
`else
   // sub is accepted on the port but has no effect in this build
   assign w_sub   = sub & 1'b0;
   assign w_b_dig = w_b_raw;
`endif

   assign w_a_dig = r_a[{r_idx, 2'b00} +: 4];
   assign w_b_raw = r_b[{r_idx, 2'b00} +: 4];
   assign w_s     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, r_carry};

   // Decimal correction of the shared single-digit adder
   always_comb begin
      w_digit = w_s[3:0];
      w_c     = 1'b0;
      if (w_s > 5'd9) begin
         w_digit = 4'(w_s - 5'd10);
         w_c     = 1'b1;
      end else begin
         w_digit = w_s[3:0];
         w_c     = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = ADD;
            end else begin
               w_next = IDLE;
            end
         end
         ADD: begin
            if (r_inv || (r_idx == 2'd3)) begin
               w_next = DONE;
            end else begin
               w_next = ADD;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register with registered busy/done decode
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != IDLE);
         r_done  <= (w_next == DONE);
      end
   end

   // Operand capture and digit-by-digit result accumulation
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_idx   <= 2'd0;
         r_carry <= 1'b0;
         r_inv   <= 1'b0;
         r_a     <= 16'h0000;
         r_b     <= 16'h0000;
         r_sum   <= 16'h0000;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
`ifdef BCD_SUB_EN
         r_sub   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_carry <= w_sub;
                  r_idx   <= 2'd0;
                  r_inv   <= w_bad;
`ifdef BCD_SUB_EN
                  r_sub   <= sub;
`endif
                  if (!w_bad) begin
                     r_err <= 1'b0;
                  end else begin
                     r_err <= r_err;
                  end
               end else begin
                  r_idx <= r_idx;
               end
            end
            ADD: begin
               if (r_inv) begin
                  r_sum  <= 16'h0000;
                  r_cout <= 1'b0;
                  r_err  <= 1'b1;
                  r_idx  <= 2'd0;
               end else begin
                  r_sum[{r_idx, 2'b00} +: 4] <= w_digit;
                  r_carry <= w_c;
                  r_idx   <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_cout <= w_c;
                  end else begin
                     r_cout <= r_cout;
                  end
               end
            end
            DONE:    r_idx <= 2'd0;
            default: r_idx <= 2'd0;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign err  = r_err;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for bcd_serial_add_ctrl (both BCD_SUB_EN builds).
module tb_bcd_serial_add_ctrl;

   logic        CLOCK_50;
   logic        reset;
   logic        start;
   logic        sub;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] sum;
   logic        cout;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks;
   int n_err;
   int cyc;
   int nd;

   bcd_serial_add_ctrl dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .start    (start),
      .sub      (sub),
      .A        (A),
      .B        (B),
      .sum      (sum),
      .cout     (cout),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Issue one request; cyc = edges after the start edge until done is seen
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output int c);
      A = a;
      B = b;
      sub = s;
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      c = 0;
      while (!done && c < 20) begin
         step();
         c++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      step();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [15:0] exp_s1, exp_s2;
      logic        exp_c1, exp_c2;
      n_checks = 0;
      n_err    = 0;
      reset = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      A     = 16'h0000;
      B     = 16'h0000;
      step();
      step();
      check("rst_sum",  {16'd0, sum}, 32'h0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err",  {31'd0, err}, 32'd0);
      reset = 1'b0;

      run_op(16'h1234, 16'h5678, 1'b0, cyc);
      check("lat_1234", cyc, 32'd4);
      check("sum_1234", {16'd0, sum}, 32'h6912);
      check("cout_1234", {31'd0, cout}, 32'd0);
      check("err_1234", {31'd0, err}, 32'd0);

      run_op(16'h9999, 16'h0001, 1'b0, cyc);
      check("sum_9999", {16'd0, sum}, 32'h0000);
      check("cout_9999", {31'd0, cout}, 32'd1);

      run_op(16'h0045, 16'h0055, 1'b0, cyc);
      check("sum_0045", {16'd0, sum}, 32'h0100);
      check("cout_0045", {31'd0, cout}, 32'd0);

      run_op(16'h00A0, 16'h0001, 1'b0, cyc);
      check("lat_inv", cyc, 32'd1);
      check("sum_inv", {16'd0, sum}, 32'h0000);
      check("cout_inv", {31'd0, cout}, 32'd0);
      check("err_inv", {31'd0, err}, 32'd1);
      step();
      step();
      check("err_hold", {31'd0, err}, 32'd1);

      run_op(16'h0001, 16'h0002, 1'b0, cyc);
      check("sum_after_inv", {16'd0, sum}, 32'h0003);
      check("err_cleared", {31'd0, err}, 32'd0);

      // start held high during ADD with new operands must be ignored
      A = 16'h1111;
      B = 16'h2222;
      start = 1'b1;
      step();
      A = 16'h5555;
      B = 16'h4444;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done) nd++;
         if (i == 2) start = 1'b0;
      end
      check("ignore_start_dones", nd, 32'd1);
      check("ignore_start_sum", {16'd0, sum}, 32'h3333);

      // reset during an operation
      A = 16'h1234;
      B = 16'h5678;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;
      check("mid_rst_sum",  {16'd0, sum}, 32'h0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_cout", {31'd0, cout}, 32'd0);
      check("mid_rst_err",  {31'd0, err}, 32'd0);
      step();
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) nd++;
      end
      check("mid_rst_no_done", nd, 32'd0);
      run_op(16'h0045, 16'h0055, 1'b0, cyc);
      check("post_rst_lat", cyc, 32'd4);
      check("post_rst_sum", {16'd0, sum}, 32'h0100);

`ifdef BCD_SUB_EN
      exp_s1 = 16'h3766; exp_c1 = 1'b1;
      exp_s2 = 16'h6234; exp_c2 = 1'b0;
`else
      exp_s1 = 16'h6234; exp_c1 = 1'b0;
      exp_s2 = 16'h6234; exp_c2 = 1'b0;
`endif
      run_op(16'h5000, 16'h1234, 1'b1, cyc);
      check("sub1_sum", {16'd0, sum}, {16'd0, exp_s1});
      check("sub1_cout", {31'd0, cout}, {31'd0, exp_c1});
      run_op(16'h1234, 16'h5000, 1'b1, cyc);
      check("sub2_sum", {16'd0, sum}, {16'd0, exp_s2});
      check("sub2_cout", {31'd0, cout}, {31'd0, exp_c2});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
